// File: rtl/dcm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dcm_ctrl_pkg
// Purpose : shared types and constants for the DCM programming controller.
//   state_e        - controller phase (IDLE, SETUP, STROBE, HOLD)
//   REQ_A / REQ_B  - requester index encoding used by the arbiter and top
//   CNT_W          - width of the phase down-counter
// ---------------------------------------------------------------------------
package dcm_ctrl_pkg;

  localparam int   CNT_W = 16;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage : dcm_ctrl_pkg

// File: rtl/dcm_ctrl_rr_arb.sv
// ---------------------------------------------------------------------------
// dcm_ctrl_rr_arb
// Purpose : two-way round-robin grant decision (purely combinational).
// Ports   :
//   req_a, req_b  in  level requests
//   last_grant    in  requester index granted most recently
//   gnt_valid     out at least one request is pending
//   gnt_idx       out requester index that wins this cycle
// ---------------------------------------------------------------------------
module dcm_ctrl_rr_arb
  import dcm_ctrl_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_idx   = REQ_A;
    if (req_a && req_b) begin
      // On a tie the requester that did not win last time goes next.
      gnt_idx = (last_grant == REQ_A) ? REQ_B : REQ_A;
    end else if (req_b) begin
      gnt_idx = REQ_B;
    end
  end

endmodule : dcm_ctrl_rr_arb

// File: rtl/dcm_prog_ctrl.sv
// ---------------------------------------------------------------------------
// dcm_prog_ctrl
// Purpose : arbitrates two requesters and sequences a rate-code update into
//           a clock manager: drive prog_out, wait SETUP_CYCLES, pulse
//           update_clock for one cycle, wait HOLD_CYCLES, then ack.
// Ports   :
//   clock, reset         in  clock; asynchronous active-high reset
//   req_a/prog_a         in  requester A level request and rate code
//   req_b/prog_b         in  requester B level request and rate code
//   ack_a, ack_b         out one-cycle completion pulses
//   prog_out             out rate code to clock manager prog_in
//   update_clock         out one-cycle strobe to clock manager
//   busy                 out high whenever state is not IDLE
// Build option:
//   DCM_CTRL_SKIP_SAME_EN - a grant whose code equals the current prog_out
//                           acks on the next cycle without any strobe.
//
// state  | meaning
// IDLE   | arbitrate (blocked in a cycle where an ack is being presented)
// SETUP  | prog_out settled, waiting SETUP_CYCLES before the strobe
// STROBE | update_clock high for exactly this cycle
// HOLD   | waiting HOLD_CYCLES before acking the owner
// ---------------------------------------------------------------------------
module dcm_prog_ctrl
  import dcm_ctrl_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic [2:0] prog_a,
  input  logic       req_b,
  input  logic [2:0] prog_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [2:0] prog_out,
  output logic       update_clock,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       prog_q, prog_d;
  logic             upd_q, upd_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;

  logic             gnt_valid;
  logic             gnt_idx;
  logic [2:0]       gnt_prog;

  dcm_ctrl_rr_arb u_arb (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign gnt_prog = (gnt_idx == REQ_B) ? prog_b : prog_a;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prog_d  = prog_q;
    last_d  = last_q;
    owner_d = owner_q;
    upd_d   = 1'b0;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;

    case (state_q)
      IDLE: begin
        // No grant while an ack is on the outputs, so the acked requester
        // gets one cycle to drop its level request.
        if (!ack_a_q && !ack_b_q && gnt_valid) begin
          prog_d  = gnt_prog;
          last_d  = gnt_idx;
          owner_d = gnt_idx;
`ifdef DCM_CTRL_SKIP_SAME_EN
          if (gnt_prog == prog_q) begin
            ack_a_d = (gnt_idx == REQ_A);
            ack_b_d = (gnt_idx == REQ_B);
          end else begin
            state_d = SETUP;
            cnt_d   = SETUP_LOAD;
          end
`else
          state_d = SETUP;
          cnt_d   = SETUP_LOAD;
`endif
        end
      end
      SETUP: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = STROBE;
          cnt_d   = CNT_ZERO;
          upd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      STROBE: begin
        state_d = HOLD;
        cnt_d   = HOLD_LOAD;
      end
      HOLD: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
          ack_a_d = (owner_q == REQ_A);
          ack_b_d = (owner_q == REQ_B);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      prog_q  <= 3'd0;
      upd_q   <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= REQ_B;
      owner_q <= REQ_A;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prog_q  <= prog_d;
      upd_q   <= upd_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  assign ack_a        = ack_a_q;
  assign ack_b        = ack_b_q;
  assign prog_out     = prog_q;
  assign update_clock = upd_q;
  assign busy         = busy_q;

endmodule : dcm_prog_ctrl

// File: tb/tb_dcm_prog_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcm_prog_ctrl
// Directed bench for dcm_prog_ctrl with default SETUP_CYCLES=2 and
// HOLD_CYCLES=16. Cycle numbering: cycle 0 is the IDLE cycle in which the
// request is first presented (the grant cycle); cycle N is observed at the
// falling edge after the Nth rising edge. With the defaults a transaction
// shows prog_out in cycle 1, SETUP in cycles 1-2, the strobe in cycle 3,
// HOLD in cycles 4-19 and the ack in cycle 20. The next grant for a
// different pending requester happens in cycle 21.
// ---------------------------------------------------------------------------
module tb_dcm_prog_ctrl;

  logic       clock;
  logic       reset;
  logic       req_a;
  logic [2:0] prog_a;
  logic       req_b;
  logic [2:0] prog_b;
  logic       ack_a;
  logic       ack_b;
  logic [2:0] prog_out;
  logic       update_clock;
  logic       busy;

  int checks;
  int errors;

  // Observation results, filled by observe().
  int         upd_cyc [4];
  logic [2:0] upd_prog [4];
  int         n_upd;
  int         n_ack_a;
  int         n_ack_b;
  int         ack_a_cyc;
  int         ack_b_cyc;
  logic [2:0] prog_at_ack_a;

  dcm_prog_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .req_a        (req_a),
    .prog_a       (prog_a),
    .req_b        (req_b),
    .prog_b       (prog_b),
    .ack_a        (ack_a),
    .ack_b        (ack_b),
    .prog_out     (prog_out),
    .update_clock (update_clock),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Watches cycles start..start+n-1. Each requester drops its request on
  // its ack unless hold_both is set, in which case both drop after 4 acks.
  task automatic observe(input int start, input int n, input bit hold_both);
    n_upd = 0; n_ack_a = 0; n_ack_b = 0;
    ack_a_cyc = -1; ack_b_cyc = -1; prog_at_ack_a = 3'd0;
    for (int i = 0; i < 4; i++) begin
      upd_cyc[i] = -1; upd_prog[i] = 3'd0;
    end
    for (int c = start; c < start + n; c++) begin
      @(negedge clock);
      if (update_clock) begin
        if (n_upd < 4) begin
          upd_cyc[n_upd]  = c;
          upd_prog[n_upd] = prog_out;
        end
        n_upd++;
      end
      if (ack_a) begin
        if (n_ack_a == 0) begin
          ack_a_cyc = c;
          prog_at_ack_a = prog_out;
        end
        n_ack_a++;
        if (!hold_both) req_a = 1'b0;
      end
      if (ack_b) begin
        if (n_ack_b == 0) ack_b_cyc = c;
        n_ack_b++;
        if (!hold_both) req_b = 1'b0;
      end
      if (hold_both && (n_ack_a + n_ack_b == 4)) begin
        req_a = 1'b0;
        req_b = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (prog_out !== 3'd0) begin errors++; $display("FAIL reset_prog got %0d want 0", prog_out); end
    checks++; if (update_clock !== 1'b0) begin errors++; $display("FAIL reset_upd got %b want 0", update_clock); end
    checks++; if ({ack_a, ack_b} !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", {ack_a, ack_b}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    req_a = 1'b1; prog_a = 3'd3;
    @(negedge clock);
    checks++; if (prog_out !== 3'd3) begin errors++; $display("FAIL single_prog got %0d want 3", prog_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    observe(2, 24, 1'b0);
    checks++; if (upd_cyc[0] != 3) begin errors++; $display("FAIL single_upd_cyc got %0d want 3", upd_cyc[0]); end
    checks++; if (n_upd != 1) begin errors++; $display("FAIL single_upd_cnt got %0d want 1", n_upd); end
    checks++; if (ack_a_cyc != 20) begin errors++; $display("FAIL single_ack_cyc got %0d want 20", ack_a_cyc); end
    checks++; if (n_ack_a != 1 || n_ack_b != 0) begin errors++; $display("FAIL single_ack_cnt got a=%0d b=%0d want a=1 b=0", n_ack_a, n_ack_b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
    checks++; if (prog_out !== 3'd3) begin errors++; $display("FAIL single_prog_end got %0d want 3", prog_out); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_a = 1'b1; prog_a = 3'd1;
    req_b = 1'b1; prog_b = 3'd6;
    observe(1, 50, 1'b0);
    checks++; if (ack_a_cyc != 20) begin errors++; $display("FAIL simul_ack_a_cyc got %0d want 20", ack_a_cyc); end
    checks++; if (ack_b_cyc != 41) begin errors++; $display("FAIL simul_ack_b_cyc got %0d want 41", ack_b_cyc); end
    checks++; if (n_ack_a != 1 || n_ack_b != 1) begin errors++; $display("FAIL simul_ack_cnt got a=%0d b=%0d want 1 1", n_ack_a, n_ack_b); end
    checks++; if (upd_cyc[1] != 24) begin errors++; $display("FAIL simul_upd_b_cyc got %0d want 24", upd_cyc[1]); end
    checks++; if (upd_prog[0] !== 3'd1 || upd_prog[1] !== 3'd6) begin errors++; $display("FAIL simul_order got %0d,%0d want 1,6", upd_prog[0], upd_prog[1]); end
  endtask

  task automatic test_contention();
    do_reset();
    req_a = 1'b1; prog_a = 3'd2;
    req_b = 1'b1; prog_b = 3'd7;
    observe(1, 90, 1'b1);
    checks++; if (n_upd != 4) begin errors++; $display("FAIL cont_upd_cnt got %0d want 4", n_upd); end
    checks++; if (upd_prog[0] !== 3'd2 || upd_prog[1] !== 3'd7 || upd_prog[2] !== 3'd2 || upd_prog[3] !== 3'd7)
      begin errors++; $display("FAIL cont_order got %0d,%0d,%0d,%0d want 2,7,2,7", upd_prog[0], upd_prog[1], upd_prog[2], upd_prog[3]); end
    checks++; if (upd_cyc[3] != 66) begin errors++; $display("FAIL cont_upd4_cyc got %0d want 66", upd_cyc[3]); end
    checks++; if (n_ack_a != 2 || n_ack_b != 2) begin errors++; $display("FAIL cont_ack_cnt got a=%0d b=%0d want 2 2", n_ack_a, n_ack_b); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_a = 1'b1; prog_a = 3'd5;
    repeat (10) @(negedge clock);
    checks++; if (busy !== 1'b1 || prog_out !== 3'd5) begin errors++; $display("FAIL midrst_pre got busy=%b prog=%0d want 1 5", busy, prog_out); end
    reset = 1'b1;
    #1;
    checks++; if (prog_out !== 3'd0) begin errors++; $display("FAIL midrst_prog got %0d want 0", prog_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    @(negedge clock);
    checks++; if (ack_a !== 1'b0 || update_clock !== 1'b0) begin errors++; $display("FAIL midrst_noack got ack=%b upd=%b want 0 0", ack_a, update_clock); end
    reset = 1'b0;
    observe(1, 24, 1'b0);
    checks++; if (ack_a_cyc != 20 || n_ack_a != 1) begin errors++; $display("FAIL midrst_reserve got cyc=%0d n=%0d want 20 1", ack_a_cyc, n_ack_a); end
    checks++; if (upd_prog[0] !== 3'd5 || upd_cyc[0] != 3) begin errors++; $display("FAIL midrst_upd got prog=%0d cyc=%0d want 5 3", upd_prog[0], upd_cyc[0]); end
  endtask

  task automatic test_busy_inputs();
    do_reset();
    req_a = 1'b1; prog_a = 3'd5;
    @(negedge clock);
    prog_a = 3'd1;
    req_b = 1'b1; prog_b = 3'd2;
    observe(2, 45, 1'b0);
    checks++; if (upd_prog[0] !== 3'd5) begin errors++; $display("FAIL busyin_upd_prog got %0d want 5", upd_prog[0]); end
    checks++; if (prog_at_ack_a !== 3'd5) begin errors++; $display("FAIL busyin_ack_prog got %0d want 5", prog_at_ack_a); end
    checks++; if (ack_a_cyc != 20) begin errors++; $display("FAIL busyin_ack_cyc got %0d want 20", ack_a_cyc); end
    checks++; if (upd_prog[1] !== 3'd2 || ack_b_cyc != 41) begin errors++; $display("FAIL busyin_b got prog=%0d cyc=%0d want 2 41", upd_prog[1], ack_b_cyc); end
  endtask

  task automatic test_same_prog();
    req_b = 1'b1; prog_b = 3'd4;
    observe(1, 24, 1'b0);
    checks++; if (ack_b_cyc != 20 || prog_out !== 3'd4) begin errors++; $display("FAIL same_first got cyc=%0d prog=%0d want 20 4", ack_b_cyc, prog_out); end
    req_b = 1'b1; prog_b = 3'd4;
    observe(1, 24, 1'b0);
`ifdef DCM_CTRL_SKIP_SAME_EN
    checks++; if (ack_b_cyc != 1) begin errors++; $display("FAIL same_ack_cyc got %0d want 1", ack_b_cyc); end
    checks++; if (n_upd != 0) begin errors++; $display("FAIL same_upd_cnt got %0d want 0", n_upd); end
`else
    checks++; if (ack_b_cyc != 20) begin errors++; $display("FAIL same_ack_cyc got %0d want 20", ack_b_cyc); end
    checks++; if (n_upd != 1 || upd_cyc[0] != 3) begin errors++; $display("FAIL same_upd got n=%0d cyc=%0d want 1 3", n_upd, upd_cyc[0]); end
`endif
    checks++; if (n_ack_b != 1 || prog_out !== 3'd4) begin errors++; $display("FAIL same_end got n=%0d prog=%0d want 1 4", n_ack_b, prog_out); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    req_a  = 1'b0; prog_a = 3'd0;
    req_b  = 1'b0; prog_b = 3'd0;
    @(negedge clock);
    test_reset();
    test_single();
    test_simultaneous();
    test_contention();
    test_mid_reset();
    test_busy_inputs();
    test_same_prog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dcm_prog_ctrl
